// File: rtl/myio_axil_reg_slave.sv
// AXI4-Lite register slave for myIO: NUM_REGS 32-bit byte-writable registers mirrored onto o_regs.
// Define MYIO_WR_IRQ_EN to add o_wr_irq, a one-cycle pulse after every write that completes OKAY.
module myio_axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] o_regs
`ifdef MYIO_WR_IRQ_EN
    ,
    output logic                                   o_wr_irq
`endif
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int IW = AW - 2;
    localparam int SW = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t          wstate_q, wstate_d;
    rstate_t          rstate_q, rstate_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             aw_hold_q, aw_hold_d;
    logic             w_hold_q, w_hold_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [DW-1:0]    regs_q [NUM_REGS];
    logic [DW-1:0]    regs_d [NUM_REGS];
    logic             irq_q, irq_d;

    logic [AW-1:0]    awaddr_q;
    logic [DW-1:0]    wdata_q;
    logic [SW-1:0]    wstrb_q;

    logic             aw_fire, w_fire, have_aw, have_w;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [SW-1:0]    wr_strb;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             wr_idx_ok, rd_idx_ok, wr_ok;
    logic [DW-1:0]    rd_val;
    logic             unused_inputs;

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        for (int b = 0; b < SW; b++)
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return res;
    endfunction

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // AW and W may arrive on different cycles; whichever comes first is parked until the other shows up.
    assign aw_fire = S_AXI_AWVALID && awready_q;
    assign w_fire  = S_AXI_WVALID && wready_q;
    assign have_aw = aw_hold_q || aw_fire;
    assign have_w  = w_hold_q || w_fire;
    assign wr_addr = aw_hold_q ? awaddr_q : S_AXI_AWADDR;
    assign wr_data = w_hold_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_hold_q ? wstrb_q : S_AXI_WSTRB;
    assign wr_idx  = wr_addr[AW-1:2];
    assign rd_idx  = S_AXI_ARADDR[AW-1:2];
    assign wr_idx_ok = 32'(wr_idx) < NUM_REGS;
    assign rd_idx_ok = 32'(rd_idx) < NUM_REGS;

    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_hold_d = aw_hold_q;
        w_hold_d  = w_hold_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_ok     = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (have_aw && have_w) begin
                    wr_ok     = wr_idx_ok;
                    bresp_d   = wr_idx_ok ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_hold_d = 1'b0;
                    w_hold_d  = 1'b0;
                    wstate_d  = W_RESP;
                end else begin
                    awready_d = !have_aw;
                    wready_d  = !have_w;
                    aw_hold_d = have_aw;
                    w_hold_d  = have_w;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
            if (wr_ok && (32'(wr_idx) == k))
                regs_d[k] = apply_strb(regs_q[k], wr_data, wr_strb);
        end
        irq_d = wr_ok;
    end

    // Reads see regs_q, so a read sampled on the same edge as a write returns the pre-write value.
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (rd_idx_ok && (32'(rd_idx) == k))
                rd_val = regs_q[k];
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && arready_q) begin
                    rdata_d   = rd_val;
                    rresp_d   = rd_idx_ok ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = R_DATA;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_hold_q <= 1'b0;
            w_hold_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++)
                regs_q[k] <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_hold_q <= aw_hold_d;
            w_hold_q  <= w_hold_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
            for (int k = 0; k < NUM_REGS; k++)
                regs_q[k] <= regs_d[k];
        end
    end

    // Parked address/data are only meaningful while their hold flag is set, so they need no reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_fire)
            awaddr_q <= S_AXI_AWADDR;
        if (w_fire) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_oregs
        assign o_regs[DW*g +: DW] = regs_q[g];
    end

`ifdef MYIO_WR_IRQ_EN
    assign o_wr_irq = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q ^ unused_inputs;
`endif

endmodule

// File: tb/tb_myio_axil_reg_slave.sv
// Directed bench for myio_axil_reg_slave (AW=5, NUM_REGS=4); exercises o_wr_irq when MYIO_WR_IRQ_EN is defined.
module tb_myio_axil_reg_slave;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [4:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [127:0] oregs;
    logic         wr_irq;

    int checks = 0;
    int errors = 0;
    int irq_cnt = 0;
    int irq_wide = 0;
    logic irq_prev = 1'b0;

    always #5 clk = ~clk;

    myio_axil_reg_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .NUM_REGS(4)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .o_regs(oregs)
`ifdef MYIO_WR_IRQ_EN
        ,
        .o_wr_irq(wr_irq)
`endif
    );

`ifdef MYIO_WR_IRQ_EN
    always @(negedge clk) begin
        if (wr_irq) irq_cnt++;
        if (wr_irq && irq_prev) irq_wide++;
        irq_prev = wr_irq;
    end
`else
    assign wr_irq = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
        chk({tag, "_r0"}, oregs[31:0], e0);
        chk({tag, "_r1"}, oregs[63:32], e1);
        chk({tag, "_r2"}, oregs[95:64], e2);
        chk({tag, "_r3"}, oregs[127:96], e3);
    endtask

    // Called just after a rising edge; w_lead delays AWVALID behind WVALID, bdelay holds BREADY low.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int bdelay, input bit ack, output logic [1:0] resp);
        int n;
        bit aw_done, w_done, awf, wf;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        awvalid = (w_lead == 0);
        aw_done = 0;
        w_done  = 0;
        n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            awf = awvalid && awready;
            wf  = wvalid && wready;
            @(posedge clk); #1;
            n++;
            if (awf) begin aw_done = 1; awvalid = 1'b0; end
            if (wf) begin w_done = 1; wvalid = 1'b0; end
            if (!aw_done && n >= w_lead) awvalid = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("wr_handshake", 32'({aw_done, w_done}), 32'd3);
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bvalid_seen", 32'(bvalid), 32'd1);
        resp = bresp;
        if (ack) begin
            for (int i = 0; i < bdelay; i++) begin
                @(posedge clk); #1;
                chk("bvalid_hold", 32'(bvalid), 32'd1);
                chk("bresp_hold", 32'(bresp), 32'(resp));
            end
            bready = 1'b1;
            @(posedge clk); #1;
            bready = 1'b0;
            chk("bvalid_drop", 32'(bvalid), 32'd0);
        end
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("rvalid", 32'(rvalid), 32'd1);
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] t1_data [4];
        t1_data[0] = 32'h1;
        t1_data[1] = 32'h2;
        t1_data[2] = 32'h3;
        t1_data[3] = 32'h4;

        // Reset state and first READY after release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk_regs("rst", 32'd0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_awready_pre", 32'(awready), 32'd0);
        @(posedge clk); #1;
        chk("rel_awready", 32'(awready), 32'd1);
        chk("rel_wready", 32'(wready), 32'd1);
        chk("rel_arready", 32'(arready), 32'd1);

        // T1: plain writes then reads
        for (int k = 0; k < 4; k++) begin
            axi_write(5'(4 * k), t1_data[k], 4'hF, 0, 0, 1'b1, resp);
            chk($sformatf("t1_bresp%0d", k), 32'(resp), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(5'(4 * k), rd, resp);
            chk($sformatf("t1_rdata%0d", k), rd, t1_data[k]);
            chk($sformatf("t1_rresp%0d", k), 32'(resp), 32'd0);
        end

        // T2: partial byte strobes
        axi_write(5'h4, 32'h11223344, 4'hF, 0, 0, 1'b1, resp);
        axi_write(5'h4, 32'hAABBCCDD, 4'b0101, 0, 0, 1'b1, resp);
        chk("t2_bresp", 32'(resp), 32'd0);
        axi_read(5'h4, rd, resp);
        chk("t2_rdata", rd, 32'h11BB33DD);

        // T3: W leads AW by 3 cycles, BREADY held off 5 cycles
        axi_write(5'h8, 32'h5A5A0001, 4'hF, 3, 5, 1'b1, resp);
        chk("t3_bresp", 32'(resp), 32'd0);
        chk_regs("t3", 32'h1, 32'h11BB33DD, 32'h5A5A0001, 32'h4);
        axi_read(5'h8, rd, resp);
        chk("t3_rdata", rd, 32'h5A5A0001);

        // WSTRB=0 leaves the register alone but still answers OKAY
        axi_write(5'hC, 32'hFFFFFFFF, 4'h0, 0, 0, 1'b1, resp);
        chk("strb0_bresp", 32'(resp), 32'd0);
        chk("strb0_r3", oregs[127:96], 32'h4);

        // T4: out-of-range index
        axi_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 0, 1'b1, resp);
        chk("t4_bresp", 32'(resp), 32'd2);
        chk_regs("t4", 32'h1, 32'h11BB33DD, 32'h5A5A0001, 32'h4);
        axi_read(5'h10, rd, resp);
        chk("t4_rdata", rd, 32'd0);
        chk("t4_rresp", 32'(resp), 32'd2);

`ifdef MYIO_WR_IRQ_EN
        // T6: two OKAY writes pulse twice, the SLVERR write not at all
        irq_cnt = 0;
        irq_wide = 0;
        axi_write(5'h0, 32'hA0, 4'hF, 0, 0, 1'b1, resp);
        axi_write(5'h4, 32'hB0, 4'hF, 0, 0, 1'b1, resp);
        @(posedge clk); #1;
        chk("t6_irq_cnt2", 32'(irq_cnt), 32'd2);
        axi_write(5'h14, 32'hC0, 4'hF, 0, 0, 1'b1, resp);
        @(posedge clk); #1;
        chk("t6_irq_slverr", 32'(irq_cnt), 32'd2);
        chk("t6_irq_width", 32'(irq_wide), 32'd0);
`endif

        // T5: reset while a write response is pending
        axi_write(5'hC, 32'h77777777, 4'hF, 0, 0, 1'b0, resp);
        chk("t5_bvalid_pre", 32'(bvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_bvalid", 32'(bvalid), 32'd0);
        chk("t5_irq", 32'(wr_irq), 32'd0);
        chk_regs("t5", 32'd0, 32'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            axi_read(5'(4 * k), rd, resp);
            chk($sformatf("t5_rdata%0d", k), rd, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
